// File: rtl/ram_1r1w_sync_be.sv
// 1-read/1-write synchronous RAM with byte-masked writes, selectable read-during-write
// forwarding, an optional read output stage and a hardware clear sequence after reset.
//
// state    | meaning
// st_clear | writing zero to word[cnt], requests ignored, ready_o=0
// st_ready | clear finished, reads and writes accepted until next reset
module ram_1r1w_sync_be #(
  parameter int width_p   = 32,
  parameter int depth_p   = 512,
  parameter int bypass_p  = 1,
  parameter int rd_pipe_p = 0
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  output logic                       ready_o,
  input  logic                       wr_valid_i,
  input  logic [width_p/8-1:0]       wr_mask_i,
  input  logic [$clog2(depth_p)-1:0] wr_addr_i,
  input  logic [width_p-1:0]         wr_data_i,
  input  logic                       rd_valid_i,
  input  logic [$clog2(depth_p)-1:0] rd_addr_i,
  output logic [width_p-1:0]         rd_data_o,
  output logic                       rd_valid_o
);
  localparam int aw = $clog2(depth_p);
  localparam int nb = width_p / 8;
  localparam logic [aw-1:0] last_addr = aw'(depth_p - 1);

  typedef enum logic {st_clear, st_ready} state_t;

  state_t        state, state_next;
  logic [aw-1:0] cnt, cnt_next;
  logic          ready;
  logic          wr_in_range, rd_in_range;
  logic          wr_en, rd_en;
  logic [width_p-1:0] stored, rd_word;
  logic [width_p-1:0] s1_data;
  logic               s1_valid;
  logic [width_p-1:0] mem [depth_p];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= st_clear;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      st_clear: begin
        if (cnt == last_addr) state_next = st_ready;
        else                  cnt_next   = cnt + 1'b1;
      end
      st_ready: state_next = st_ready;
      default:  state_next = st_clear;
    endcase
  end

  assign ready   = (state == st_ready);
  assign ready_o = ready;

  // Addresses past the last word only exist when depth is not a power of two.
  if ((1 << aw) == depth_p) begin : g_pow2
    assign wr_in_range = 1'b1;
    assign rd_in_range = 1'b1;
  end else begin : g_npow2
    assign wr_in_range = (wr_addr_i <= last_addr);
    assign rd_in_range = (rd_addr_i <= last_addr);
  end

  assign wr_en = ready & wr_valid_i & wr_in_range;
  assign rd_en = ready & rd_valid_i;

  always_ff @(posedge clk_i) begin
    if (!ready) begin
      mem[cnt] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < nb; b++) begin
        if (wr_mask_i[b]) mem[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    stored  = rd_in_range ? mem[rd_addr_i] : '0;
    rd_word = stored;
    if ((bypass_p != 0) && wr_en && (wr_addr_i == rd_addr_i)) begin
      for (int b = 0; b < nb; b++) begin
        if (wr_mask_i[b]) rd_word[8*b +: 8] = wr_data_i[8*b +: 8];
      end
    end
  end

  // Data registers load only on a completing read so the output holds otherwise.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_en;
      if (rd_en) s1_data <= rd_word;
    end
  end

  if (rd_pipe_p != 0) begin : g_pipe
    logic [width_p-1:0] s2_data;
    logic               s2_valid;

    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign rd_data_o  = s2_data;
    assign rd_valid_o = s2_valid;
  end else begin : g_nopipe
    assign rd_data_o  = s1_data;
    assign rd_valid_o = s1_valid;
  end

endmodule
